// File: rtl/serial_rx_if.sv
// Receive-side word handshake: producer holds rx_data/rx_id while rx_valid,
// consumer pulses rx_ack to take the word.
interface serial_rx_if;
  logic [39:0] rx_data;
  logic [7:0]  rx_id;
  logic        rx_valid;
  logic        rx_ack;

  modport master (output rx_data, rx_id, rx_valid, input rx_ack);
  modport slave  (input rx_data, rx_id, rx_valid, output rx_ack);
endinterface

// File: rtl/serial_rx.sv
// Serial frame receiver: header hunt, zero destuffing, 48-bit deserialise,
// even parity / stop check, device-id filter and valid/ack delivery.
module serial_rx #(
  parameter int HDR_ONES  = 5,
  parameter int STUFF_RUN = 4,
  parameter int STOP_BITS = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        sd_in,
  input  logic [7:0]  my_id,
  input  logic        promisc,
  serial_rx_if.master rx,
  output logic        busy,
  output logic        err_parity,
  output logic        err_frame,
  output logic        err_overrun
);
  localparam int DATA_BITS = 48;
  localparam int ONES_W    = $clog2(HDR_ONES + 1);
  localparam int RUN_W     = $clog2(STUFF_RUN + 1);
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {HUNT, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                par_acc_q, par_acc_d;
  logic                par_bad_q, par_bad_d;
  logic [39:0]         rx_data_q, rx_data_d;
  logic [7:0]          rx_id_q, rx_id_d;
  logic                rx_valid_q, rx_valid_d;
  logic                err_parity_q, err_parity_d;
  logic                err_frame_q, err_frame_d;
  logic                err_overrun_q, err_overrun_d;

  logic frame_err;
  logic frame_done;
  logic id_match;
  logic deliver;
  logic accept;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= HUNT;
      ones_q        <= '0;
      run_q         <= '0;
      cnt_q         <= '0;
      shift_q       <= '0;
      par_acc_q     <= 1'b0;
      par_bad_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_id_q       <= '0;
      rx_valid_q    <= 1'b0;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ones_q        <= ones_d;
      run_q         <= run_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      par_acc_q     <= par_acc_d;
      par_bad_q     <= par_bad_d;
      rx_data_q     <= rx_data_d;
      rx_id_q       <= rx_id_d;
      rx_valid_q    <= rx_valid_d;
      err_parity_q  <= err_parity_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    run_d      = run_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    par_bad_d  = par_bad_q;
    frame_err  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      HUNT: begin
        if (!sd_in) begin
          ones_d = '0;
        end else if (ones_q == ONES_W'(HDR_ONES - 1)) begin
          state_d   = DATA;
          ones_d    = '0;
          run_d     = '0;
          cnt_d     = '0;
          par_acc_d = 1'b0;
          par_bad_d = 1'b0;
        end else begin
          ones_d = ones_q + 1'b1;
        end
      end
      DATA, STOP: begin
        // A full ones run means this bit is a stuff bit: must be 0 and is dropped.
        if (run_q == RUN_W'(STUFF_RUN)) begin
          run_d = '0;
          if (sd_in) begin
            frame_err = 1'b1;
            state_d   = HUNT;
          end
        end else begin
          run_d = sd_in ? run_q + 1'b1 : '0;
          if (state_q == DATA) begin
            if (cnt_q == CNT_W'(DATA_BITS)) begin
              par_bad_d = par_acc_q ^ sd_in;
              cnt_d     = '0;
              state_d   = STOP;
            end else begin
              shift_d   = {sd_in, shift_q[DATA_BITS-1:1]};
              par_acc_d = par_acc_q ^ sd_in;
              cnt_d     = cnt_q + 1'b1;
            end
          end else if (sd_in) begin
            frame_err = 1'b1;
            state_d   = HUNT;
          end else if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            state_d    = HUNT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Line order is id, data[39:32], data[31:0], so the first-received bit lands in shift_q[0].
  always_comb begin
    id_match      = promisc || (shift_q[7:0] == my_id);
    deliver       = frame_done && !par_bad_q && id_match;
    accept        = deliver && (!rx_valid_q || rx.rx_ack);
    rx_valid_d    = accept || (rx_valid_q && !rx.rx_ack);
    rx_data_d     = accept ? {shift_q[15:8], shift_q[47:16]} : rx_data_q;
    rx_id_d       = accept ? shift_q[7:0] : rx_id_q;
    err_parity_d  = frame_done && par_bad_q;
    err_frame_d   = frame_err;
    err_overrun_d = deliver && rx_valid_q && !rx.rx_ack;
  end

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_id     = rx_id_q;
  assign rx.rx_valid  = rx_valid_q;
  assign busy         = (state_q != HUNT);
  assign err_parity   = err_parity_q;
  assign err_frame    = err_frame_q;
  assign err_overrun  = err_overrun_q;
endmodule
